// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage F/D/E/M/W core.
// A shadow scoreboard tracks the E, M and W instructions' destinations so that
// load-use, branch-use and operand-forwarding decisions can be made on the
// decode-stage register addresses alone.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   rs1_d, rs2_d, rd_d           decode register addresses
//   rd_write_d, rd_write_src_d   decode writeback enable / source
//   branch, branch_d             decode branch reads rs1/rs2; branch taken
//   mem_valid_f                  fetch output valid
//   dmem_req_m, dmem_ready_m     M-stage data memory handshake
//   stall_f/d/e/m, flush_d/e     pipeline register controls
//   forwarding_rs1_d/rs2_d       early-branch operand taken from alu_res_e
//   fwd_rs1_e, fwd_rs2_e         execute operand select (00 rf, 01 M, 10 W)
//   stall_cnt, flush_cnt         performance counters
module hazard_ctrl #(
    parameter logic [1:0]  SRC_LOAD = 2'b01,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_d,
    input  logic             rd_write_d,
    input  logic [1:0]       rd_write_src_d,
    input  logic             branch,
    input  logic             branch_d,
    input  logic             mem_valid_f,
    input  logic             dmem_req_m,
    input  logic             dmem_ready_m,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             stall_e,
    output logic             flush_e,
    output logic             stall_m,
    output logic             forwarding_rs1_d,
    output logic             forwarding_rs2_d,
    output logic [1:0]       fwd_rs1_e,
    output logic [1:0]       fwd_rs2_e,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned REG_W = 5;

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    logic [0:0] state;
    logic [0:0] state_next;

    // Scoreboard: E keeps its sources for execute forwarding; M/W only the write.
    logic [REG_W-1:0] e_rs1, e_rs2, e_rd;
    logic             e_wr, e_load;
    logic [REG_W-1:0] m_rd;
    logic             m_wr, m_load;
    logic [REG_W-1:0] w_rd;
    logic             w_wr;

    logic mem_stall;
    logic load_use;
    logic branch_use;
    logic e_fwd_ok;
    logic m_valid, w_valid;
    logic redirect;

    // A write to x0 is never a producer.
    assign m_valid = m_wr && (m_rd != '0);
    assign w_valid = w_wr && (w_rd != '0);

    // Stall on the very first cycle the access is not ready, and every
    // following cycle until ready; the ready cycle itself proceeds.
    assign mem_stall = (dmem_req_m || (state == MEM_WAIT)) && !dmem_ready_m;

    // Both sources are treated as used, which is conservative but safe.
    assign load_use = e_wr && e_load && (e_rd != '0)
                   && ((e_rd == rs1_d) || (e_rd == rs2_d));

    // A branch resolves in D, so a load still in M cannot be forwarded to it.
    assign branch_use = branch && m_wr && m_load && (m_rd != '0)
                     && ((m_rd == rs1_d) || (m_rd == rs2_d));

    assign e_fwd_ok = branch && e_wr && !e_load && (e_rd != '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and control outputs, highest-priority hazard first.
    always_comb begin
        state_next       = state;
        stall_f          = 1'b0;
        stall_d          = 1'b0;
        flush_d          = 1'b0;
        stall_e          = 1'b0;
        flush_e          = 1'b0;
        stall_m          = 1'b0;
        forwarding_rs1_d = 1'b0;
        forwarding_rs2_d = 1'b0;
        fwd_rs1_e        = 2'b00;
        fwd_rs2_e        = 2'b00;
        redirect         = 1'b0;

        if (mem_stall) begin
            state_next = MEM_WAIT;
            stall_f    = 1'b1;
            stall_d    = 1'b1;
            stall_e    = 1'b1;
            stall_m    = 1'b1;
        end else begin
            state_next = RUN;
            if (load_use || branch_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else begin
                forwarding_rs1_d = e_fwd_ok && (e_rd == rs1_d);
                forwarding_rs2_d = e_fwd_ok && (e_rd == rs2_d);
                redirect         = branch_d;
                flush_d          = branch_d || !mem_valid_f;
            end
        end

        // Execute operand selects; M is younger so it wins over W.
        if (m_valid && (m_rd == e_rs1)) begin
            fwd_rs1_e = 2'b01;
        end else if (w_valid && (w_rd == e_rs1)) begin
            fwd_rs1_e = 2'b10;
        end
        if (m_valid && (m_rd == e_rs2)) begin
            fwd_rs2_e = 2'b01;
        end else if (w_valid && (w_rd == e_rs2)) begin
            fwd_rs2_e = 2'b10;
        end

        // Reset forces every control quiet, regardless of inputs.
        if (!rst_n) begin
            stall_f          = 1'b0;
            stall_d          = 1'b0;
            flush_d          = 1'b0;
            stall_e          = 1'b0;
            flush_e          = 1'b0;
            stall_m          = 1'b0;
            forwarding_rs1_d = 1'b0;
            forwarding_rs2_d = 1'b0;
            fwd_rs1_e        = 2'b00;
            fwd_rs2_e        = 2'b00;
            redirect         = 1'b0;
        end
    end

    // Shadow scoreboard, advancing in step with the pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_rs1  <= '0;
            e_rs2  <= '0;
            e_rd   <= '0;
            e_wr   <= 1'b0;
            e_load <= 1'b0;
            m_rd   <= '0;
            m_wr   <= 1'b0;
            m_load <= 1'b0;
            w_rd   <= '0;
            w_wr   <= 1'b0;
        end else begin
            if (!stall_m) begin
                w_rd   <= m_rd;
                w_wr   <= m_wr;
                m_rd   <= e_rd;
                m_wr   <= e_wr;
                m_load <= e_load;
            end
            if (!stall_e) begin
                if (flush_e) begin
                    e_rs1  <= '0;
                    e_rs2  <= '0;
                    e_rd   <= '0;
                    e_wr   <= 1'b0;
                    e_load <= 1'b0;
                end else begin
                    e_rs1  <= rs1_d;
                    e_rs2  <= rs2_d;
                    e_rd   <= rd_d;
                    e_wr   <= rd_write_d;
                    e_load <= (rd_write_src_d == SRC_LOAD);
                end
            end
        end
    end

    // Performance counters, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(stall_d);
            flush_cnt <= flush_cnt + CNT_W'(redirect);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change on the falling edge and
// outputs are checked 1 ns later, well away from the rising edge.
module tb_hazard_ctrl;

    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_ALU  = 2'b00;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        rd_write_d;
    logic [1:0]  rd_write_src_d;
    logic        branch, branch_d, mem_valid_f;
    logic        dmem_req_m, dmem_ready_m;
    logic        stall_f, stall_d, flush_d, stall_e, flush_e, stall_m;
    logic        forwarding_rs1_d, forwarding_rs2_d;
    logic [1:0]  fwd_rs1_e, fwd_rs2_e;
    logic [31:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl #(.SRC_LOAD(SRC_LOAD), .CNT_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rs1_d            (rs1_d),
        .rs2_d            (rs2_d),
        .rd_d             (rd_d),
        .rd_write_d       (rd_write_d),
        .rd_write_src_d   (rd_write_src_d),
        .branch           (branch),
        .branch_d         (branch_d),
        .mem_valid_f      (mem_valid_f),
        .dmem_req_m       (dmem_req_m),
        .dmem_ready_m     (dmem_ready_m),
        .stall_f          (stall_f),
        .stall_d          (stall_d),
        .flush_d          (flush_d),
        .stall_e          (stall_e),
        .flush_e          (flush_e),
        .stall_m          (stall_m),
        .forwarding_rs1_d (forwarding_rs1_d),
        .forwarding_rs2_d (forwarding_rs2_d),
        .fwd_rs1_e        (fwd_rs1_e),
        .fwd_rs2_e        (fwd_rs2_e),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rs1_d          = '0;
        rs2_d          = '0;
        rd_d           = '0;
        rd_write_d     = 1'b0;
        rd_write_src_d = SRC_ALU;
        branch         = 1'b0;
        branch_d       = 1'b0;
        mem_valid_f    = 1'b1;
        dmem_req_m     = 1'b0;
        dmem_ready_m   = 1'b0;
    endtask

    task automatic set_d(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic wr, input logic [1:0] src, input logic br);
        rs1_d          = r1;
        rs2_d          = r2;
        rd_d           = rd;
        rd_write_d     = wr;
        rd_write_src_d = src;
        branch         = br;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall_f"}, 32'(stall_f), 32'd0);
        check({tag, "_stall_d"}, 32'(stall_d), 32'd0);
        check({tag, "_flush_d"}, 32'(flush_d), 32'd0);
        check({tag, "_stall_e"}, 32'(stall_e), 32'd0);
        check({tag, "_flush_e"}, 32'(flush_e), 32'd0);
        check({tag, "_stall_m"}, 32'(stall_m), 32'd0);
        check({tag, "_fwd_d1"}, 32'(forwarding_rs1_d), 32'd0);
        check({tag, "_fwd_d2"}, 32'(forwarding_rs2_d), 32'd0);
        check({tag, "_fwd_e1"}, 32'(fwd_rs1_e), 32'd0);
        check({tag, "_fwd_e2"}, 32'(fwd_rs2_e), 32'd0);
        check({tag, "_stall_cnt"}, stall_cnt, 32'd0);
        check({tag, "_flush_cnt"}, flush_cnt, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        // Held in reset with provoking inputs: everything stays quiet.
        @(negedge clk);
        branch_d = 1'b1; mem_valid_f = 1'b0; dmem_req_m = 1'b1;
        #1 check_quiet("rst");

        // Load-use: lw x5 then add x6,x5,x1.
        @(negedge clk); rst_n = 1'b1; idle(); set_d(5'd2, 5'd0, 5'd5, 1'b1, SRC_LOAD, 1'b0);
        #1 check("lu_pre_stall_d", 32'(stall_d), 32'd0);
        @(negedge clk); idle(); set_d(5'd5, 5'd1, 5'd6, 1'b1, SRC_ALU, 1'b0);
        #1 check("lu_stall_d", 32'(stall_d), 32'd1);
        check("lu_stall_f", 32'(stall_f), 32'd1);
        check("lu_flush_e", 32'(flush_e), 32'd1);
        check("lu_stall_m", 32'(stall_m), 32'd0);
        check("lu_flush_d", 32'(flush_d), 32'd0);
        @(negedge clk);
        #1 check("lu_release", 32'(stall_d), 32'd0);
        check("lu_flush_e_off", 32'(flush_e), 32'd0);
        check("lu_stall_cnt", stall_cnt, 32'd1);
        @(negedge clk); idle();
        #1 check("lu_fwd_e1", 32'(fwd_rs1_e), 32'd2);
        check("lu_fwd_e2", 32'(fwd_rs2_e), 32'd0);

        // Branch forward from E: addi x3 then beq x3,x4.
        @(negedge clk); idle(); set_d(5'd1, 5'd0, 5'd3, 1'b1, SRC_ALU, 1'b0);
        @(negedge clk); idle(); set_d(5'd3, 5'd4, 5'd0, 1'b0, SRC_ALU, 1'b1);
        #1 check("bf_fwd_d1", 32'(forwarding_rs1_d), 32'd1);
        check("bf_fwd_d2", 32'(forwarding_rs2_d), 32'd0);
        check("bf_stall_d", 32'(stall_d), 32'd0);
        // Same shape through x0: no forward.
        @(negedge clk); idle(); set_d(5'd1, 5'd0, 5'd0, 1'b1, SRC_ALU, 1'b0);
        @(negedge clk); idle(); set_d(5'd0, 5'd4, 5'd0, 1'b0, SRC_ALU, 1'b1);
        #1 check("bf_x0_fwd_d1", 32'(forwarding_rs1_d), 32'd0);
        check("bf_x0_fwd_d2", 32'(forwarding_rs2_d), 32'd0);

        // Branch-use on a load in M: lw x8, add x9, beq x8,x1.
        @(negedge clk); idle(); set_d(5'd2, 5'd0, 5'd8, 1'b1, SRC_LOAD, 1'b0);
        @(negedge clk); idle(); set_d(5'd1, 5'd2, 5'd9, 1'b1, SRC_ALU, 1'b0);
        #1 check("bu_no_stall", 32'(stall_d), 32'd0);
        @(negedge clk); idle(); set_d(5'd8, 5'd1, 5'd0, 1'b0, SRC_ALU, 1'b1);
        #1 check("bu_stall_d", 32'(stall_d), 32'd1);
        check("bu_flush_e", 32'(flush_e), 32'd1);
        check("bu_fwd_d1", 32'(forwarding_rs1_d), 32'd0);
        @(negedge clk);
        #1 check("bu_release", 32'(stall_d), 32'd0);
        check("bu_stall_cnt", stall_cnt, 32'd2);

        // Taken branch then fetch bubble.
        @(negedge clk); idle(); branch_d = 1'b1;
        #1 check("tb_flush_d", 32'(flush_d), 32'd1);
        check("tb_stall_d", 32'(stall_d), 32'd0);
        @(negedge clk); idle();
        #1 check("tb_flush_off", 32'(flush_d), 32'd0);
        check("tb_flush_cnt", flush_cnt, 32'd1);
        @(negedge clk); idle(); mem_valid_f = 1'b0;
        #1 check("fb_flush_d", 32'(flush_d), 32'd1);
        @(negedge clk); idle();
        #1 check("fb_flush_off", 32'(flush_d), 32'd0);
        check("fb_flush_cnt", flush_cnt, 32'd1);

        // Data memory wait: add x10 into M, sub x11,x10,x10 in E, 3 not-ready cycles.
        @(negedge clk); idle(); set_d(5'd1, 5'd2, 5'd10, 1'b1, SRC_ALU, 1'b0);
        @(negedge clk); idle(); set_d(5'd10, 5'd10, 5'd11, 1'b1, SRC_ALU, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); dmem_req_m = 1'b1; branch_d = 1'b1;
            #1 check($sformatf("mw%0d_stall_f", i), 32'(stall_f), 32'd1);
            check($sformatf("mw%0d_stall_d", i), 32'(stall_d), 32'd1);
            check($sformatf("mw%0d_stall_e", i), 32'(stall_e), 32'd1);
            check($sformatf("mw%0d_stall_m", i), 32'(stall_m), 32'd1);
            check($sformatf("mw%0d_flush_d", i), 32'(flush_d), 32'd0);
            check($sformatf("mw%0d_flush_e", i), 32'(flush_e), 32'd0);
            check($sformatf("mw%0d_fwd_e1", i), 32'(fwd_rs1_e), 32'd1);
            check($sformatf("mw%0d_fwd_e2", i), 32'(fwd_rs2_e), 32'd1);
            check($sformatf("mw%0d_stall_cnt", i), stall_cnt, 32'(2 + i));
        end
        @(negedge clk); idle(); dmem_req_m = 1'b1; dmem_ready_m = 1'b1; branch_d = 1'b1;
        #1 check("mw_rdy_stall_m", 32'(stall_m), 32'd0);
        check("mw_rdy_stall_d", 32'(stall_d), 32'd0);
        check("mw_rdy_flush_d", 32'(flush_d), 32'd1);
        check("mw_rdy_fwd_e1", 32'(fwd_rs1_e), 32'd1);
        check("mw_rdy_stall_cnt", stall_cnt, 32'd5);
        @(negedge clk); idle();
        #1 check("mw_after_flush_d", 32'(flush_d), 32'd0);
        check("mw_after_stall_m", 32'(stall_m), 32'd0);
        check("mw_after_flush_cnt", flush_cnt, 32'd2);
        check("mw_after_stall_cnt", stall_cnt, 32'd5);

        // Double forward: x7 in both M and W, E reads x7 on rs2.
        @(negedge clk); idle(); set_d(5'd1, 5'd0, 5'd7, 1'b1, SRC_ALU, 1'b0);
        @(negedge clk); idle(); set_d(5'd1, 5'd0, 5'd7, 1'b1, SRC_ALU, 1'b0);
        @(negedge clk); idle(); set_d(5'd1, 5'd7, 5'd12, 1'b1, SRC_ALU, 1'b0);
        @(negedge clk); idle();
        #1 check("df_m_fwd_e2", 32'(fwd_rs2_e), 32'd1);
        check("df_m_fwd_e1", 32'(fwd_rs1_e), 32'd0);
        // Now M names x7 but does not write it: W must be selected.
        @(negedge clk); idle(); set_d(5'd1, 5'd0, 5'd7, 1'b1, SRC_ALU, 1'b0);
        @(negedge clk); idle(); set_d(5'd2, 5'd3, 5'd7, 1'b0, SRC_ALU, 1'b0);
        @(negedge clk); idle(); set_d(5'd1, 5'd7, 5'd12, 1'b1, SRC_ALU, 1'b0);
        @(negedge clk); idle();
        #1 check("df_w_fwd_e2", 32'(fwd_rs2_e), 32'd2);
        check("df_w_fwd_e1", 32'(fwd_rs1_e), 32'd0);

        // Reset in the middle of a memory wait.
        @(negedge clk); idle(); dmem_req_m = 1'b1;
        #1 check("rw_stall_m", 32'(stall_m), 32'd1);
        @(negedge clk); rst_n = 1'b0; branch_d = 1'b1;
        #1 check_quiet("rw_rst");
        @(negedge clk); rst_n = 1'b1; idle();
        #1 check("rw_run_stall_m", 32'(stall_m), 32'd0);
        check("rw_run_stall_d", 32'(stall_d), 32'd0);
        @(negedge clk); idle(); branch_d = 1'b1;
        #1 check("rw_flush_d", 32'(flush_d), 32'd1);
        @(negedge clk); idle();
        #1 check("rw_flush_cnt", flush_cnt, 32'd1);
        check("rw_stall_cnt", stall_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
